qoa_lms_predictor: RTL and testbench

QOA_LMS_PREDICTOR -- requirements
Module: qoa_lms_predictor

---
 rtl/qoa_pkg.sv | 23 ++
 rtl/qoa_lms_predictor_if.sv | 28 ++
 rtl/qoa_mac.sv | 25 ++
 rtl/qoa_lms_predictor.sv | 92 +++++++++
 tb/tb_qoa_lms_predictor.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/qoa_pkg.sv
// rtl/qoa_pkg.sv - shared widths, state encoding and saturation helper for the QOA LMS predictor
package qoa_pkg;
  localparam int TAPS     = 4;
  localparam int IDX_W    = 2;
  localparam int SAMPLE_W = 16;
  localparam int WEIGHT_W = 16;
  localparam int PROD_W   = SAMPLE_W + WEIGHT_W;
  localparam int ACC_W    = 34;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // One bit wider than the accumulator so the scaled sum plus residual cannot wrap.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W:0] v);
    if (v > 35'sd32767)
      return 16'sh7fff;
    else if (v < -35'sd32768)
      return 16'sh8000;
    else
      return v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/qoa_lms_predictor_if.sv
// rtl/qoa_lms_predictor_if.sv - load, residual and sample handshake bundle
interface qoa_lms_predictor_if;
  import qoa_pkg::*;

  logic                       load_valid;
  logic [IDX_W-1:0]           load_index;
  logic signed [SAMPLE_W-1:0] load_history;
  logic signed [WEIGHT_W-1:0] load_weight;
  logic                       res_valid;
  logic                       res_ready;
  logic signed [SAMPLE_W-1:0] residual;
  logic                       sample_valid;
  logic                       sample_ready;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       busy;

  modport master (
    output load_valid, load_index, load_history, load_weight,
    output res_valid, residual, sample_ready,
    input  res_ready, sample_valid, sample, busy
  );

  modport slave (
    input  load_valid, load_index, load_history, load_weight,
    input  res_valid, residual, sample_ready,
    output res_ready, sample_valid, sample, busy
  );
endinterface

// File: rtl/qoa_mac.sv
// rtl/qoa_mac.sv - signed 16x16 multiply feeding a 34-bit accumulator
module qoa_mac
  import qoa_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [WEIGHT_W-1:0] b,
  output logic signed [ACC_W-1:0]    acc
);
  logic signed [PROD_W-1:0] product;

  assign product = PROD_W'(a) * PROD_W'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clear)
      acc <= '0;
    else if (en)
      acc <= acc + ACC_W'(product);
  end
endmodule

// File: rtl/qoa_lms_predictor.sv
// rtl/qoa_lms_predictor.sv - 4-tap QOA LMS predictor: serial MAC, clamp, sign-LMS weight update
module qoa_lms_predictor
  import qoa_pkg::*;
#(
  parameter int SCALE_SHIFT = 13,
  parameter int DELTA_SHIFT = 4
) (
  input logic                clk,
  input logic                restart,
  qoa_lms_predictor_if.slave bus
);
  logic [1:0]                 state;
  logic [2:0]                 tap;
  logic signed [SAMPLE_W-1:0] res_q;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic                       sample_valid_q;
  logic signed [SAMPLE_W-1:0] history [TAPS];
  logic signed [WEIGHT_W-1:0] weight  [TAPS];
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W:0]      sum;
  logic signed [WEIGHT_W-1:0] delta;
  logic                       accept;

  assign bus.res_ready    = (state == ST_IDLE) && !bus.load_valid;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;

  assign accept = bus.res_valid && bus.res_ready;
  assign sum    = (ACC_W+1)'(acc >>> SCALE_SHIFT) + (ACC_W+1)'(res_q);
  assign delta  = res_q >>> DELTA_SHIFT;

  // tap[2] set means all four products are in the accumulator.
  qoa_mac u_mac (
    .clk   (clk),
    .rst   (restart),
    .clear (accept),
    .en    ((state == ST_MAC) && !tap[2]),
    .a     (history[tap[1:0]]),
    .b     (weight[tap[1:0]]),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state          <= ST_IDLE;
      tap            <= '0;
      res_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        history[i] <= '0;
        weight[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_MAC;
            tap   <= '0;
            res_q <= bus.residual;
          end else if (bus.load_valid) begin
            history[bus.load_index] <= bus.load_history;
            weight[bus.load_index]  <= bus.load_weight;
          end
        end
        ST_MAC: begin
          if (tap[2]) begin
            sample_q       <= sat_sample(sum);
            sample_valid_q <= 1'b1;
            state          <= ST_OUT;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        ST_OUT: begin
          if (bus.sample_ready) begin
            // Weight signs come from the pre-shift history.
            for (int i = 0; i < TAPS; i++)
              weight[i] <= history[i][SAMPLE_W-1] ? weight[i] - delta : weight[i] + delta;
            for (int i = 0; i < TAPS-1; i++)
              history[i] <= history[i+1];
            history[TAPS-1] <= sample_q;
            sample_valid_q  <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qoa_lms_predictor.sv
// tb/tb_qoa_lms_predictor.sv - scoreboard bench for the QOA LMS predictor
module tb_qoa_lms_predictor;
  import qoa_pkg::*;

  logic clk = 1'b0;
  logic restart;
  always #5 clk = ~clk;

  qoa_lms_predictor_if bus ();

  qoa_lms_predictor #(.SCALE_SHIFT(13), .DELTA_SHIFT(4)) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  longint exp_q[$];
  longint last_sample;
  logic signed [15:0] mh [4];
  logic signed [15:0] mw [4];

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint model_predict(input int res);
    longint dot = 0;
    longint s;
    for (int k = 0; k < 4; k++) dot += longint'(mh[k]) * longint'(mw[k]);
    s = (dot >>> 13) + longint'(res);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_update(input int res, input longint s);
    logic signed [15:0] d;
    d = 16'(res >>> 4);
    for (int i = 0; i < 4; i++) mw[i] = (mh[i] < 0) ? mw[i] - d : mw[i] + d;
    for (int i = 0; i < 3; i++) mh[i] = mh[i+1];
    mh[3] = 16'(s);
  endtask

  task automatic check_taps();
    for (int i = 0; i < 4; i++) begin
      check("tap_history", dut.history[i], mh[i]);
      check("tap_weight", dut.weight[i], mw[i]);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    #2;
    check("rst_valid", bus.sample_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sample", bus.sample, 0);
    check("rst_acc", dut.u_mac.acc, 0);
    for (int i = 0; i < 4; i++) begin
      mh[i] = '0;
      mw[i] = '0;
    end
    check_taps();
    restart = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_tap(input int idx, input int h, input int w);
    bus.load_valid   = 1'b1;
    bus.load_index   = 2'(idx);
    bus.load_history = 16'(h);
    bus.load_weight  = 16'(w);
    #1;
    check("load_blocks_res", bus.res_ready, 0);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    mh[idx] = 16'(h);
    mw[idx] = 16'(w);
  endtask

  task automatic send(input int res, input int hold, input bit mac_load);
    int n;
    longint s0;
    longint exp_s;
    exp_q.push_back(model_predict(res));
    bus.res_valid = 1'b1;
    bus.residual  = 16'(res);
    #1;
    check("res_ready_idle", bus.res_ready, 1);
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    check("busy_mac", bus.busy, 1);
    n = 0;
    if (mac_load) begin
      bus.load_valid   = 1'b1;
      bus.load_index   = 2'd1;
      bus.load_history = 16'sd1234;
      bus.load_weight  = 16'sd555;
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      n = 1;
    end
    while (!bus.sample_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 5);
    s0 = bus.sample;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.sample_valid, 1);
      check("hold_sample", bus.sample, s0);
      check("hold_res_ready", bus.res_ready, 0);
      check("hold_state", dut.state, ST_OUT);
    end
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      check("sample", bus.sample, exp_s);
      last_sample = bus.sample;
      bus.sample_ready = 1'b1;
      @(posedge clk); #1;
      bus.sample_ready = 1'b0;
      check("valid_drop", bus.sample_valid, 0);
      check("idle_after", bus.busy, 0);
      model_update(res, exp_s);
      check_taps();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    restart          = 1'b1;
    bus.load_valid   = 1'b0;
    bus.load_index   = '0;
    bus.load_history = '0;
    bus.load_weight  = '0;
    bus.res_valid    = 1'b0;
    bus.residual     = '0;
    bus.sample_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mh[i] = '0;
      mw[i] = '0;
    end
    #12;
    check("reset_valid", bus.sample_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_res_ready", bus.res_ready, 1);
    check("reset_sample", bus.sample, 0);
    check_taps();
    restart = 1'b0;
    @(posedge clk); #1;

    send(100, 0, 0);
    check("zero_state_sample", last_sample, 100);
    for (int i = 0; i < 4; i++) check("w_after_100", dut.weight[i], 6);
    check("h3_after_100", dut.history[3], 100);

    bus.sample_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ready_busy", bus.busy, 0);
      check("idle_ready_valid", bus.sample_valid, 0);
    end
    bus.sample_ready = 1'b0;
    check_taps();

    load_tap(0, 0, 0);
    load_tap(1, 0, 0);
    load_tap(2, -1000, -8192);
    load_tap(3, 2000, 16384);
    send(0, 0, 0);
    check("dot_sample", last_sample, 5000);
    check("dot_w2", dut.weight[2], -8192);
    check("dot_w3", dut.weight[3], 16384);

    for (int i = 0; i < 3; i++) load_tap(i, 0, 0);
    load_tap(3, 30000, 16384);
    send(10000, 10, 0);
    check("clamp_hi", last_sample, 32767);
    for (int i = 0; i < 3; i++) load_tap(i, 0, 0);
    load_tap(3, -30000, 16384);
    send(-10000, 0, 0);
    check("clamp_lo", last_sample, -32768);

    bus.res_valid = 1'b1;
    bus.residual  = 16'sd55;
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_in_mac", bus.busy, 1);
    do_restart();
    repeat (8) begin
      @(posedge clk); #1;
      check("abort_no_valid", bus.sample_valid, 0);
    end
    send(7, 0, 0);
    check("after_abort", last_sample, 7);

    bus.res_valid    = 1'b1;
    bus.residual     = -16'sd1;
    bus.load_valid   = 1'b1;
    bus.load_index   = 2'd0;
    bus.load_history = -16'sd5;
    bus.load_weight  = 16'sd20;
    #1;
    check("load_res_ready", bus.res_ready, 0);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.res_valid  = 1'b0;
    check("load_not_busy", bus.busy, 0);
    check("load_h0", dut.history[0], -5);
    check("load_w0", dut.weight[0], 20);
    mh[0] = -16'sd5;
    mw[0] = 16'sd20;
    send(-1, 3, 1);
    check("neg_delta_w0", dut.weight[0], 21);
    check("neg_sample", last_sample, -2);

    for (int t = 0; t < 6; t++) begin
      load_tap(t % 4, int'($urandom_range(20000)) - 10000, int'($urandom_range(40000)) - 20000);
      send(int'($urandom_range(4000)) - 2000, t % 3, 1'(t % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
